// File: rtl/mult_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_controller_pkg
// Brief    : Shared state encoding and default operand width for the
//            shift-add multiplier controller, its datapath wrapper and benches.
// Revision : 1.0
// ============================================================================
package mult_controller_pkg;

    localparam int unsigned DEFAULT_WIDTH = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        TEST  = 3'd2,
        ADD   = 3'd3,
        SHIFT = 3'd4,
        DONE  = 3'd5
    } state_e;

endpackage
`default_nettype wire

// File: rtl/mult_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : mult_controller_if
// Brief    : Request/result handshake bundle between a client and the
//            multiplier controller.
// Revision : 1.0
// ============================================================================
interface mult_controller_if
    import mult_controller_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic                 start;
    logic                 start_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic [2*WIDTH-1:0]   result;
    logic                 result_valid;
    logic                 result_ready;
    logic                 busy;

    modport master (
        output start, in_a, in_b, result_ready,
        input  start_ready, result, result_valid, busy
    );

    modport slave (
        input  start, in_a, in_b, result_ready,
        output start_ready, result, result_valid, busy
    );

endinterface
`default_nettype wire

// File: rtl/mult_controller.sv
`default_nettype none
// ============================================================================
// Module   : mult_controller
// Brief    : Moore FSM sequencing a shift-add multiplier datapath, with a
//            start/ready request port and a valid/ready result port.
// Revision : 1.0
// ============================================================================
module mult_controller
    import mult_controller_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    mult_controller_if.slave          req,
    output logic      [WIDTH-1:0]     inA,
    output logic      [WIDTH-1:0]     inB,
    output logic                      loadRegs,
    output logic                      addRegs,
    output logic                      shiftReg,
    output logic                      decrement,
    input  wire logic                 Zbit,
    input  wire logic                 Mbit,
    input  wire logic [2*WIDTH-1:0]   product
);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     inA_q, inA_d;
    logic [WIDTH-1:0]     inB_q, inB_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            inA_q    <= '0;
            inB_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            inA_q    <= inA_d;
            inB_q    <= inB_d;
            result_q <= result_d;
        end
    end

    // Outputs depend only on state_q; inputs steer the next state and captures.
    always_comb begin
        state_d   = state_q;
        inA_d     = inA_q;
        inB_d     = inB_q;
        result_d  = result_q;
        loadRegs  = 1'b0;
        addRegs   = 1'b0;
        shiftReg  = 1'b0;
        decrement = 1'b0;
        case (state_q)
            IDLE: begin
                if (req.start) begin
                    state_d = LOAD;
                    inA_d   = req.in_a;
                    inB_d   = req.in_b;
                end
            end
            LOAD: begin
                loadRegs = 1'b1;
                state_d  = TEST;
            end
            TEST: begin
                if (Zbit) begin
                    state_d  = DONE;
                    result_d = product;
                end else if (Mbit) begin
                    state_d = ADD;
                end else begin
                    state_d = SHIFT;
                end
            end
            ADD: begin
                addRegs = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: begin
                shiftReg  = 1'b1;
                decrement = 1'b1;
                state_d   = TEST;
            end
            DONE: begin
                if (req.result_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req.start_ready  = (state_q == IDLE);
    assign req.busy         = (state_q != IDLE);
    assign req.result_valid = (state_q == DONE);
    assign req.result       = result_q;
    assign inA              = inA_q;
    assign inB              = inB_q;

endmodule
`default_nettype wire
